// File: rtl/operand_feeder_pkg.sv
// Shared types and defaults for the operand feeder: FSM encoding, operand/opcode widths,
// the packed operand-pair record and default buffer depth / finish timeout.
package operand_feeder_pkg;

    localparam int OP_W            = 8;
    localparam int OPC_W           = 3;
    localparam int DEFAULT_DEPTH   = 16;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } pair_t;

endpackage

// File: rtl/operand_buffer.sv
// DEPTH-entry operand-pair store filled in order; count/full registered, clear wins over write.
// Read port is registered: rd_dat_o holds the addressed entry one cycle after rd_en_i, else zero.
module operand_buffer
    import operand_feeder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         wr_en_i,
    input  pair_t                        wr_dat_i,
    input  logic                         rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr_i,
    output pair_t                        rd_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    pair_t         mem_q [DEPTH];
    pair_t         rd_dat_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          wr_ok;

    // Writes to a full buffer are dropped so the stored pairs stay intact.
    assign wr_ok = wr_en_i && !clr_i && !full_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (wr_ok) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            count_q  <= count_d;
            full_q   <= (count_d == CW'(DEPTH));
            rd_dat_q <= rd_en_i ? mem_q[rd_addr_i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[count_q[AW-1:0]] <= wr_dat_i;
        end
    end

    assign rd_dat_o = rd_dat_q;
    assign count_o  = count_q;
    assign full_o   = full_q;

endmodule

// File: rtl/operand_feeder.sv
// Loads operand pairs, then on go emits start and streams them with valid/one_left; captures maximum on finish.
// First beat two cycles after go; throttle high suppresses the next cycle's beat; WAIT times out after TIMEOUT cycles.
module operand_feeder
    import operand_feeder_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [OP_W-1:0]            wr_a,
    input  logic [OP_W-1:0]            wr_b,
    input  logic                       clr,
    input  logic                       go,
    input  logic [OPC_W-1:0]           cfg_instr,
    input  logic                       throttle,
    input  logic                       finish,
    input  logic [OP_W-1:0]            maximum,
    output logic                       start,
    output logic                       valid,
    output logic [OP_W-1:0]            Data_A,
    output logic [OP_W-1:0]            Data_B,
    output logic                       one_left,
    output logic [OPC_W-1:0]           instruction,
    output logic                       busy,
    output logic                       done,
    output logic [OP_W-1:0]            result,
    output logic                       timeout_err,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    remaining;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             start_q, start_d;
    logic             valid_q, valid_d;
    logic             one_left_q, one_left_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             terr_q, terr_d;
    logic [OPC_W-1:0] instr_q, instr_d;
    logic [OP_W-1:0]  result_q, result_d;

    logic             go_acc, issue, stream_end, tmo_hit;
    logic             buf_wr_en, buf_clr;
    pair_t            rd_dat;

    assign go_acc     = (state_q == ST_IDLE) && go && (count != '0);
    assign issue      = ((state_q == ST_START) || (state_q == ST_STREAM)) && !throttle && (rd_ptr_q != count);
    assign stream_end = (state_q == ST_STREAM) && (rd_ptr_q == count);
    assign tmo_hit    = (tmo_q == TW'(TIMEOUT - 1));
    assign remaining  = count - rd_ptr_q;

    // Host writes only land while idle and not launching a job.
    assign buf_wr_en = (state_q == ST_IDLE) && !go_acc && wr_en;
    assign buf_clr   = (state_q == ST_IDLE) && !go_acc && clr;

    operand_buffer #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (buf_clr),
        .wr_en_i   (buf_wr_en),
        .wr_dat_i  ('{a: wr_a, b: wr_b}),
        .rd_en_i   (issue),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_dat_o  (rd_dat),
        .count_o   (count),
        .full_o    (full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (go_acc) state_d = ST_START;
            ST_START:  state_d = ST_STREAM;
            ST_STREAM: if (stream_end) state_d = ST_WAIT;
            ST_WAIT:   if (finish || tmo_hit) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        tmo_d      = tmo_q;
        start_d    = go_acc;
        valid_d    = issue;
        one_left_d = 1'b0;
        busy_d     = (state_d != ST_IDLE);
        done_d     = 1'b0;
        terr_d     = terr_q;
        instr_d    = instr_q;
        result_d   = result_q;

        if (go_acc) begin
            instr_d  = cfg_instr;
            terr_d   = 1'b0;
            rd_ptr_d = '0;
        end

        // one_left rises with the penultimate beat and holds across throttle gaps until the last beat.
        if (issue) begin
            rd_ptr_d   = rd_ptr_q + CW'(1);
            one_left_d = (remaining <= CW'(2));
        end else if (state_q == ST_STREAM && !stream_end) begin
            one_left_d = one_left_q;
        end

        if (stream_end) begin
            tmo_d = '0;
        end

        if (state_q == ST_WAIT) begin
            if (finish) begin
                result_d = maximum;
                done_d   = 1'b1;
            end else if (tmo_hit) begin
                terr_d = 1'b1;
                done_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            tmo_q      <= '0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            one_left_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            terr_q     <= 1'b0;
            instr_q    <= '0;
            result_q   <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            tmo_q      <= tmo_d;
            start_q    <= start_d;
            valid_q    <= valid_d;
            one_left_q <= one_left_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            terr_q     <= terr_d;
            instr_q    <= instr_d;
            result_q   <= result_d;
        end
    end

    assign start       = start_q;
    assign valid       = valid_q;
    assign Data_A      = rd_dat.a;
    assign Data_B      = rd_dat.b;
    assign one_left    = one_left_q;
    assign instruction = instr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_operand_feeder.sv
// Bench for operand_feeder: directed and random jobs checked against a queue-based model of the stream rules.
module tb_operand_feeder;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;

    logic       clk, rst, wr_en, clr, go, throttle, finish;
    logic [7:0] wr_a, wr_b, maximum;
    logic [2:0] cfg_instr;
    logic       start, valid, one_left, busy, done, timeout_err, full;
    logic [7:0] Data_A, Data_B, result;
    logic [2:0] instruction;
    logic [4:0] count;

    operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .clr(clr),
        .go(go), .cfg_instr(cfg_instr), .throttle(throttle), .finish(finish), .maximum(maximum),
        .start(start), .valid(valid), .Data_A(Data_A), .Data_B(Data_B), .one_left(one_left),
        .instruction(instruction), .busy(busy), .done(done), .result(result),
        .timeout_err(timeout_err), .count(count), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_bad = 0;
    logic [15:0] mdl_buf[$];
    logic [7:0]  mdl_result = 8'h00;
    logic        mdl_terr = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_pair(input logic [7:0] a, input logic [7:0] b);
        wr_en = 1'b1; wr_a = a; wr_b = b;
        tick();
        wr_en = 1'b0;
        if (mdl_buf.size() < DEPTH) mdl_buf.push_back({a, b});
        check_eq("load_count", count, mdl_buf.size());
        check_eq("load_full", full, mdl_buf.size() == DEPTH);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mdl_buf.delete();
        check_eq("clr_count", count, 0);
    endtask

    // fin_dly = cycles after the final beat at which finish is pulsed; 0 means never.
    task automatic run_job(input logic [2:0] instr, input int thr_mode, input int fin_dly, input logic [7:0] maxv);
        int   n, issued, cyc, wait_cyc;
        logic thr, exp_ol;
        n = mdl_buf.size();
        cfg_instr = instr; go = 1'b1;
        tick();
        go = 1'b0; cfg_instr = 3'($urandom);
        mdl_terr = 1'b0;
        check_eq("start_pulse", {start, valid, busy, done}, 4'b1010);
        check_eq("start_instr", instruction, instr);
        check_eq("go_clears_terr", timeout_err, 0);
        issued = 0; cyc = 0;
        while (issued < n && cyc < 200) begin
            case (thr_mode)
                0:       thr = 1'b0;
                1:       thr = (cyc % 2) == 1;
                default: thr = ($urandom_range(0, 2) == 0);
            endcase
            throttle = thr;
            tick();
            cyc++;
            check_eq("beat_valid", valid, !thr);
            check_eq("stream_ctl", {start, busy, instruction}, {1'b0, 1'b1, instr});
            if (valid) begin
                check_eq("beat_data", {Data_A, Data_B}, mdl_buf[issued]);
                exp_ol = (issued >= n - 2);
                issued++;
            end else begin
                check_eq("gap_data", {Data_A, Data_B}, 0);
                exp_ol = (issued >= 1) && (issued >= n - 1);
            end
            check_eq("one_left", one_left, exp_ol);
        end
        throttle = 1'b0;
        check_eq("stream_beats", issued, n);
        wait_cyc = (fin_dly > 0) ? fin_dly : TIMEOUT;
        for (int i = 1; i <= wait_cyc; i++) begin
            tick();
            check_eq("wait_quiet", {valid, one_left, done, busy}, 4'b0001);
            check_eq("wait_instr", instruction, instr);
        end
        if (fin_dly > 0) begin
            finish = 1'b1; maximum = maxv;
            mdl_result = maxv;
        end else begin
            mdl_terr = 1'b1;
        end
        tick();
        finish = 1'b0; maximum = 8'($urandom);
        check_eq("done_pulse", {done, busy, valid}, 3'b100);
        check_eq("result", result, mdl_result);
        check_eq("timeout_err", timeout_err, mdl_terr);
        tick();
        check_eq("done_cleared", done, 0);
        check_eq("terr_sticky", timeout_err, mdl_terr);
        check_eq("count_kept", count, n);
    endtask

    initial begin
        int n, mode, fd;
        logic [7:0] a, b, mx;
        rst = 1'b1; wr_en = 1'b0; clr = 1'b0; go = 1'b0; throttle = 1'b0; finish = 1'b0;
        wr_a = '0; wr_b = '0; maximum = '0; cfg_instr = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outputs", {start, valid, Data_A, Data_B, one_left, instruction, busy, done,
                                   result, timeout_err, count, full}, 0);
        rst = 1'b0;

        go = 1'b1; tick(); go = 1'b0;
        check_eq("go_empty_ignored", {start, busy}, 0);

        wr_pair(8'd3, 8'd5); wr_pair(8'd9, 8'd1); wr_pair(8'd4, 8'd4);
        run_job(3'd2, 0, 2, 8'h0E);

        finish = 1'b1; maximum = 8'hAA; tick(); finish = 1'b0;
        check_eq("finish_idle_ignored", {done, result}, {1'b0, mdl_result});

        run_job(3'd5, 2, 1, 8'h09);

        do_clr();
        for (int i = 0; i < 4; i++) wr_pair(8'(i * 17 + 1), 8'(200 - i));
        run_job(3'd1, 1, 3, 8'hC8);

        do_clr();
        wr_pair(8'd7, 8'd2);
        run_job(3'd4, 0, 5, 8'h07);

        run_job(3'd3, 0, 0, 8'h00);
        run_job(3'd6, 1, TIMEOUT, 8'h55);

        do_clr();
        for (int i = 0; i < DEPTH + 1; i++) wr_pair(8'($urandom), 8'($urandom));
        check_eq("full_count", {full, count}, {1'b1, 5'd16});
        run_job(3'd0, 2, 10, 8'h33);
        clr = 1'b1; wr_en = 1'b1; wr_a = 8'h11; wr_b = 8'h22;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        mdl_buf.delete();
        check_eq("clr_beats_wr", {full, count}, 0);

        wr_pair(8'd10, 8'd20); wr_pair(8'd30, 8'd40); wr_pair(8'd50, 8'd60); wr_pair(8'd70, 8'd80);
        cfg_instr = 3'd7; go = 1'b1; tick(); go = 1'b0;
        tick();
        tick();
        check_eq("pre_rst_beat2", {valid, Data_A}, {1'b1, 8'd30});
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_outputs", {start, valid, Data_A, Data_B, one_left, instruction, busy, done,
                                       result, timeout_err, count, full}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mdl_buf.delete(); mdl_result = 8'h00; mdl_terr = 1'b0;
        go = 1'b1; tick(); go = 1'b0;
        check_eq("go_after_rst_ignored", {start, busy, count}, 0);
        wr_pair(8'd1, 8'd2); wr_pair(8'd3, 8'd4);
        run_job(3'd2, 0, 4, 8'h04);

        for (int j = 0; j < 8; j++) begin
            do_clr();
            n = $urandom_range(1, DEPTH);
            mx = 8'h00;
            for (int i = 0; i < n; i++) begin
                a = 8'($urandom); b = 8'($urandom);
                if (a > mx) mx = a;
                if (b > mx) mx = b;
                wr_pair(a, b);
            end
            mode = $urandom_range(0, 2);
            fd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, TIMEOUT);
            run_job(3'($urandom), mode, fd, mx);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
- Producer/driver end of the find-max stream protocol. Loads up to DEPTH operand pairs from a host write port, then on `go` issues a `start` pulse and streams the pairs with `valid`/`one_left`, holding `instruction` steady.
- Waits for the consumer's `finish`, then captures its `maximum` into a status register.
- Sits between the host/testbench controller and the max-finder datapath.

Parameters:
- DEPTH, 16, number of operand-pair entries in the buffer (power of 2, ≥2)
- TIMEOUT, 64, cycles allowed in WAIT for `finish` before declaring a timeout (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- wr_en  in  1  write one operand pair into the buffer
- wr_a  in  8  operand A for write
- wr_b  in  8  operand B for write
- clr  in  1  empty the buffer
- go  in  1  launch a job
- cfg_instr  in  3  opcode for the job
- throttle  in  1  consumer back-pressure; no beat is issued while high
- finish  in  1  consumer completion pulse
- maximum  in  8  consumer result, valid when `finish`=1
- start  out  1  one-cycle job-start pulse
- valid  out  1  beat qualifier
- Data_A  out  8  operand A of the current beat
- Data_B  out  8  operand B of the current beat
- one_left  out  1  final-item indicator (see Behaviour)
- instruction  out  3  opcode held for the whole job
- busy  out  1  job in progress (state ≠ IDLE)
- done  out  1  one-cycle job-complete pulse
- result  out  8  captured maximum
- timeout_err  out  1  sticky: last job timed out
- count  out  $clog2(DEPTH+1)  entries loaded
- full  out  1  count == DEPTH

Behaviour:
- Reset (async, rst=1):
  - State IDLE; count=0, rd_ptr=0.
  - All outputs 0, including result, instruction and timeout_err.
- All outputs are registered.
- IDLE:
  - `clr`=1 → count=0. `clr` wins over `wr_en` in the same cycle.
  - `wr_en`=1 with not full → entry[count]={wr_a,wr_b}, count+1.
  - `wr_en` when full is ignored; buffer and count are unchanged.
  - `go`=1 with count>0 → START. In that edge: latch `cfg_instr` into `instruction`, clear `timeout_err`, set rd_ptr=0.
  - `go` has priority over `wr_en`/`clr` in the same cycle; those are ignored.
  - `go` with count=0 is ignored.
- START (one cycle): `start`=1, `valid`=0 → STREAM.
- STREAM:
  - `throttle` is sampled each cycle. If low, the next cycle presents a beat: `valid`=1, Data_A/Data_B=entry[rd_ptr], and rd_ptr increments.
  - If `throttle` is high, the next cycle has `valid`=0 and Data_A/Data_B=0.
  - Fastest case: `go` at cycle t → `start` at t+1 → first beat at t+2, with N beats on consecutive cycles.
- one_left:
  - Goes high with the penultimate beat and stays high, through any throttle gaps, up to and including the final beat.
  - For count=1, it is high with the only beat.
  - Deasserts in the cycle after the final beat.
- After the final beat → WAIT. Exactly `count` beats are issued per job.
- WAIT:
  - The timeout counter runs from 0.
  - `finish`=1 → result←`maximum`, `done`=1 for one cycle, → IDLE.
  - Counter reaches TIMEOUT without `finish` → `timeout_err`=1, result unchanged, `done`=1, → IDLE.
  - `finish` in the same cycle as counter expiry: `finish` wins and no error is flagged.
- `finish` outside WAIT is ignored.
- `go`, `wr_en` and `clr` are ignored while busy.
- `instruction` is stable from START through WAIT.
- Buffer contents survive job completion, so a second `go` replays the same data.
- Reset mid-job aborts immediately to the reset values listed above.

Decomposition:
- Shared package:
  - State encodings IDLE/START/STREAM/WAIT (2-bit).
  - Operand width 8 and opcode width 3.
  - Default DEPTH and TIMEOUT.
- One sub-module, operand_buffer:
  - DEPTH×16-bit register file with write pointer/count, clear, and a registered read port addressed by rd_ptr.
  - The FSM, counters and output registers stay in operand_feeder.

Test Plan:
- Load (3,5),(9,1),(4,4), cfg_instr=2, `go`, `throttle`=0:
  - `start` at t+1; `valid` t+2..t+4 with A=3,9,4 and B=5,1,4.
  - `one_left`=1 at t+3 and t+4; `instruction`=2 throughout.
  - `finish`, maximum=0x0E, issued 2 cycles after the final beat → result=0x0E, `done` pulse, `busy`=0.
- Load 4 pairs, `throttle` high on alternate cycles:
  - Exactly 4 `valid` beats, in order, with Data=0 in gap cycles.
  - `one_left` held high across the gap between beats 3 and 4.
- count=1, pair (7,2), `go`: the single beat has `valid`=1 and `one_left`=1 in the same cycle.
- Never assert `finish`, TIMEOUT=64:
  - `done` and `timeout_err` assert 64 cycles into WAIT; result is unchanged.
  - Next `go` clears `timeout_err`.
- Write 17 pairs with DEPTH=16: `full`=1 and count=16; the 17th pair never appears in the stream. Then `clr`+`wr_en` in the same cycle → count=0.
- Assert `rst` during STREAM beat 2: all outputs go to 0 asynchronously; state IDLE with count=0. `go` after reset is ignored until pairs are reloaded.
